video_timing_rx: RTL and testbench

- Receive-side counterpart of the HD/VD timing generator. Samples level-type HD (line data-enable) and VD (frame data-enable) on clk and recovers the active-pixel coordinates (x, y).
- Measures line total, line active and frame active sizes, and runs a lock FSM that declares the timing stable after LOCK_FRAMES identical frames.
- Sits at the input of downstream pixel consumers (capture, checker, sensor-interface logic) that need coordinates and a trustworthy lock/error indication.

---
 rtl/video_timing_pkg.sv | 20 ++
 rtl/video_edge_det.sv | 27 ++
 rtl/video_timing_rx.sv | 201 ++++++++++++++++++++
 tb/tb_video_timing_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types for the HD/VD timing generator and receiver.
package video_timing_pkg;

  localparam int unsigned H_W_DEF = 16;
  localparam int unsigned V_W_DEF = 13;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } vt_state_t;

  // Measurement triple at default widths.
  typedef struct packed {
    logic [H_W_DEF-1:0] h_total;
    logic [H_W_DEF-1:0] h_active;
    logic [V_W_DEF-1:0] v_active;
  } meas_t;

endpackage

// File: rtl/video_edge_det.sv
// Registered level sample plus previous sample, with rise/fall decode.
module video_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic p,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
      p <= RST_VAL;
    end else begin
      q <= din;
      p <= q;
    end
  end

  assign rise = q & ~p;
  assign fall = ~q & p;

endmodule

// File: rtl/video_timing_rx.sv
// Recovers active-pixel coordinates from level HD/VD, measures line/frame
// sizes and declares lock after LOCK_FRAMES identical frames.
module video_timing_rx
  import video_timing_pkg::*;
#(
  parameter int unsigned H_W         = H_W_DEF,
  parameter int unsigned V_W         = V_W_DEF,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hd,
  input  logic           vd,
  output logic           active,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           sol,
  output logic           sof,
  output logic [H_W-1:0] h_total,
  output logic [H_W-1:0] h_active,
  output logic [V_W-1:0] v_active,
  output logic           frame_done,
  output logic           locked,
  output logic           err
);

  typedef struct packed {
    logic [H_W-1:0] h_total;
    logic [H_W-1:0] h_active;
    logic [V_W-1:0] v_active;
  } triple_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  logic hd_q, hd_p, hd_rise, hd_fall;
  logic vd_q, vd_p, vd_rise, vd_fall;

  video_edge_det #(.RST_VAL(1'b1)) u_hd (
    .clk(clk), .rst(rst), .din(hd), .q(hd_q), .p(hd_p), .rise(hd_rise), .fall(hd_fall)
  );

  video_edge_det #(.RST_VAL(1'b1)) u_vd (
    .clk(clk), .rst(rst), .din(vd), .q(vd_q), .p(vd_p), .rise(vd_rise), .fall(vd_fall)
  );

  vt_state_t      state, state_nxt;
  logic [3:0]     match_cnt, match_nxt;
  logic [H_W-1:0] hcnt, hcnt_nxt, x_nxt, cur_tot, cur_act;
  logic [V_W-1:0] lines_nxt;
  logic           h_valid, a_valid, have_tot, have_act, frame_bad, sat_flag;
  triple_t        ref_m, new_m;
  logic           track_en, pix_on, run_start, line_inc, tot_take, act_take;
  logic           sat_h, sat_x, sat_l, sat_any, sat_new;
  logic           frame_end, bad_all, mismatch, store_en, mis_err;

  // vd_rise counts as tracking so a pixel coincident with frame start is not lost.
  always_comb begin
    pix_on    = hd_q & vd_q;
    track_en  = (state != IDLE) | vd_rise;
    run_start = pix_on & ~(hd_p & vd_p);
    line_inc  = hd_fall & (vd_q | vd_p) & ~vd_rise;
    tot_take  = hd_rise & h_valid & vd_q & track_en & ~vd_rise;
    act_take  = hd_fall & a_valid & (vd_q | vd_p) & track_en & ~vd_rise;

    sat_h    = ~hd_rise & (hcnt == '1);
    hcnt_nxt = hcnt;
    if (hd_rise)     hcnt_nxt = H_W'(1);
    else if (!sat_h) hcnt_nxt = hcnt + 1'b1;

    sat_x = pix_on & ~run_start & (x == '1);
    x_nxt = x;
    if (pix_on) begin
      if (run_start)   x_nxt = '0;
      else if (!sat_x) x_nxt = x + 1'b1;
    end

    sat_l     = line_inc & (y == '1);
    lines_nxt = y;
    if (vd_rise)                 lines_nxt = '0;
    else if (line_inc && !sat_l) lines_nxt = y + 1'b1;

    sat_any = sat_h | sat_x | sat_l;
    sat_new = sat_any & ~sat_flag & track_en;

    // A final line ending together with vd_fall contributes its sample here.
    frame_end        = vd_fall & (state != IDLE);
    new_m.h_total    = cur_tot;
    new_m.h_active   = have_act ? cur_act : hcnt;
    new_m.v_active   = lines_nxt;
    bad_all  = frame_bad | sat_flag | sat_any | ~have_tot | ~(have_act | act_take)
             | (act_take & have_act & (hcnt != cur_act));
    mismatch = bad_all | (new_m != ref_m);
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    store_en  = 1'b0;
    mis_err   = 1'b0;
    case (state)
      IDLE: if (vd_rise) state_nxt = TRACK;
      TRACK, LOCKED: begin
        if (frame_end) begin
          if (!mismatch) begin
            match_nxt = (match_cnt >= LOCK_N) ? LOCK_N : match_cnt + 1'b1;
          end else begin
            match_nxt = 4'd1;
            store_en  = 1'b1;
          end
          if (state == TRACK) begin
            if (match_nxt == LOCK_N) state_nxt = LOCKED;
          end else if (mismatch) begin
            state_nxt = TRACK;
            mis_err   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      match_cnt <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      locked    <= (state_nxt == LOCKED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt       <= '0;
      x          <= '0;
      y          <= '0;
      active     <= 1'b0;
      sol        <= 1'b0;
      sof        <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      h_total    <= '0;
      h_active   <= '0;
      v_active   <= '0;
      ref_m      <= '0;
      cur_tot    <= '0;
      cur_act    <= '0;
      h_valid    <= 1'b0;
      a_valid    <= 1'b0;
      have_tot   <= 1'b0;
      have_act   <= 1'b0;
      frame_bad  <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      hcnt       <= hcnt_nxt;
      x          <= x_nxt;
      y          <= lines_nxt;
      active     <= track_en & pix_on;
      sol        <= track_en & run_start;
      sof        <= track_en & run_start & (lines_nxt == '0);
      frame_done <= frame_end;
      err        <= sat_new | mis_err;
      sat_flag   <= (sat_flag & ~vd_rise) | (sat_any & track_en);
      if (frame_end) begin
        h_total  <= new_m.h_total;
        h_active <= new_m.h_active;
        v_active <= new_m.v_active;
      end
      if (store_en) ref_m <= new_m;
      // The first hd_rise of a frame only arms h_total; its count spans unknown history.
      if (vd_rise)      h_valid <= hd_rise;
      else if (hd_rise) h_valid <= 1'b1;
      if (hd_rise) a_valid <= 1'b1;
      if (vd_rise) begin
        have_tot  <= 1'b0;
        have_act  <= 1'b0;
        frame_bad <= 1'b0;
      end else begin
        if (tot_take) begin
          if (!have_tot) begin
            cur_tot  <= hcnt;
            have_tot <= 1'b1;
          end else if (hcnt != cur_tot) begin
            frame_bad <= 1'b1;
          end
        end
        if (act_take) begin
          if (!have_act) begin
            cur_act  <= hcnt;
            have_act <= 1'b1;
          end else if (hcnt != cur_act) begin
            frame_bad <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_rx.sv
// Scoreboard bench: generator-shaped HD/VD frames with directed glitches and resets.
module tb_video_timing_rx;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hd = 1'b0, vd = 1'b0, hd2 = 1'b0, vd2 = 1'b0;

  logic        active, sol, sof, frame_done, locked, err;
  logic [15:0] x, h_total, h_active;
  logic [12:0] y, v_active;

  logic        active2, sol2, sof2, frame_done2, locked2, err2;
  logic [3:0]  x2, h_total2, h_active2;
  logic [12:0] y2, v_active2;

  video_timing_rx #(.H_W(16), .V_W(13), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .hd(hd), .vd(vd), .active(active), .x(x), .y(y),
    .sol(sol), .sof(sof), .h_total(h_total), .h_active(h_active), .v_active(v_active),
    .frame_done(frame_done), .locked(locked), .err(err)
  );

  video_timing_rx #(.H_W(4), .V_W(13), .LOCK_FRAMES(2)) u_sat (
    .clk(clk), .rst(rst), .hd(hd2), .vd(vd2), .active(active2), .x(x2), .y(y2),
    .sol(sol2), .sof(sof2), .h_total(h_total2), .h_active(h_active2), .v_active(v_active2),
    .frame_done(frame_done2), .locked(locked2), .err(err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit sol;
    bit sof;
  } pix_t;

  typedef struct {
    meas_t m;
    bit    chk;
    bit    lk;
    bit    er;
  } fd_t;

  pix_t pix_q[$];
  fd_t  fd_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   err2_cnt = 0;
  bit   expect_track = 1'b0;
  bit   final_chk = 1'b0;
  bit   final_done = 1'b0;

  task automatic step(input logic h, input logic v);
    @(posedge clk);
    #1;
    hd = h;
    vd = v;
  endtask

  task automatic blank_line();
    for (int c = 0; c < 64; c++) step(c >= 7, 1'b0);
  endtask

  // 31 active lines then one blanking line; the generator's line 0 comes last.
  task automatic drive_frame(input int short_ln, input int rst_ln,
                             input bit lk, input bit er, input bit chk);
    fd_t f;
    expect_track = 1'b1;
    for (int ln = 1; ln <= 31; ln++) begin
      for (int c = 0; c < ((ln == short_ln) ? 63 : 64); c++) begin
        step(c >= 7, 1'b1);
        if (expect_track && c >= 7)
          pix_q.push_back('{x: c - 7, y: ln - 1, sol: (c == 7), sof: (c == 7) && (ln == 1)});
        if (ln == rst_ln && c == 20) begin
          rst = 1'b1;
          expect_track = 1'b0;
          pix_q.delete();
          fd_q.delete();
        end
        if (ln == rst_ln && c == 23) rst = 1'b0;
      end
    end
    if (expect_track) begin
      f.m   = '{h_total: 16'd64, h_active: 16'd57, v_active: 13'd31};
      f.chk = chk;
      f.lk  = lk;
      f.er  = er;
      fd_q.push_back(f);
    end
    blank_line();
  endtask

  always @(negedge clk) begin
    pix_t  ep;
    fd_t   ef;
    meas_t got;
    if (rst) begin
      n_tests++;
      if (active || sol || sof || frame_done || locked || err || x != '0 || y != '0 ||
          h_total != '0 || h_active != '0 || v_active != '0) begin
        n_fail++;
        $display("FAIL reset_state active=%0b locked=%0b x=%0d y=%0d h_total=%0d v_active=%0d required all 0",
                 active, locked, x, y, h_total, v_active);
      end
      n_tests++;
      if (active2 || sol2 || sof2 || frame_done2 || locked2 || err2 || x2 != '0 || y2 != '0 ||
          h_total2 != '0 || h_active2 != '0 || v_active2 != '0) begin
        n_fail++;
        $display("FAIL reset_state_sat active=%0b x=%0d err=%0b required all 0", active2, x2, err2);
      end
    end else begin
      if (active) begin
        n_tests++;
        if (pix_q.size() == 0) begin
          n_fail++;
          $display("FAIL pix_unexpected x=%0d y=%0d sof=%0b required no active pixel", x, y, sof);
        end else begin
          ep = pix_q.pop_front();
          if (int'(x) != ep.x || int'(y) != ep.y || sol != ep.sol || sof != ep.sof) begin
            n_fail++;
            $display("FAIL pix x=%0d y=%0d sol=%0b sof=%0b required x=%0d y=%0d sol=%0b sof=%0b",
                     x, y, sol, sof, ep.x, ep.y, ep.sol, ep.sof);
          end
        end
      end else if (sol || sof) begin
        n_tests++;
        n_fail++;
        $display("FAIL sol_sof_idle sol=%0b sof=%0b required 0 0", sol, sof);
      end
      if (frame_done) begin
        n_tests++;
        got = '{h_total: h_total, h_active: h_active, v_active: v_active};
        if (fd_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_done_unexpected locked=%0b err=%0b required no frame_done", locked, err);
        end else begin
          ef = fd_q.pop_front();
          if ((ef.chk && got != ef.m) || locked != ef.lk || err != ef.er) begin
            n_fail++;
            $display("FAIL frame_done h_total=%0d h_active=%0d v_active=%0d locked=%0b err=%0b required %0d %0d %0d locked=%0b err=%0b",
                     h_total, h_active, v_active, locked, err,
                     ef.m.h_total, ef.m.h_active, ef.m.v_active, ef.lk, ef.er);
          end
        end
      end else if (err) begin
        n_tests++;
        n_fail++;
        $display("FAIL err_spurious err=%0b required 0", err);
      end
      if (err2) err2_cnt++;
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      n_tests++;
      if (pix_q.size() != 0 || fd_q.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain pix_left=%0d fd_left=%0d required 0 0", pix_q.size(), fd_q.size());
      end
      n_tests++;
      if (err2_cnt != 1) begin
        n_fail++;
        $display("FAIL sat_err_pulses got=%0d required 1", err2_cnt);
      end
      n_tests++;
      if (x2 != 4'd15 || !active2) begin
        n_fail++;
        $display("FAIL sat_x x=%0d active=%0b required x=15 active=1", x2, active2);
      end
      n_tests++;
      if (locked2) begin
        n_fail++;
        $display("FAIL sat_locked locked=%0b required 0", locked2);
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    blank_line();
    drive_frame(0, 0, 1'b0, 1'b0, 1'b1);
    drive_frame(0, 0, 1'b1, 1'b0, 1'b1);
    drive_frame(0, 0, 1'b1, 1'b0, 1'b1);
    drive_frame(10, 0, 1'b0, 1'b1, 1'b0);
    drive_frame(0, 0, 1'b1, 1'b0, 1'b1);
    drive_frame(0, 5, 1'b1, 1'b0, 1'b1);
    drive_frame(0, 0, 1'b0, 1'b0, 1'b1);
    drive_frame(0, 0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    hd2 = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    vd2 = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    final_chk = 1'b1;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
